// File: rtl/fault_qualifier_pkg.sv
// Shared types and cause encodings for the fault qualifier and its consumers.
package fault_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SUSPECT   = 2'd1,
    CONFIRMED = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_PERSIST = 2'b01;
  localparam logic [1:0] CAUSE_GLITCH  = 2'b10;

endpackage

// File: rtl/fault_qualifier_if.sv
// Fault qualifier bus: raw sensor input in, qualified fault status out.
// The clear pulse only exists when FAULT_CLEAR_EN is defined.
interface fault_qualifier_if #(
  parameter int GLITCH_LIMIT = 4
);
  localparam int GW = $clog2(GLITCH_LIMIT + 1);

  logic          raw_fault;
  logic          true_fault;
  logic [1:0]    fault_cause;
  logic          suspect;
  logic [GW-1:0] glitch_cnt;
`ifdef FAULT_CLEAR_EN
  logic          clear;
`endif

  modport master (
`ifdef FAULT_CLEAR_EN
    output clear,
`endif
    output raw_fault,
    input  true_fault,
    input  fault_cause,
    input  suspect,
    input  glitch_cnt
  );

  modport slave (
`ifdef FAULT_CLEAR_EN
    input  clear,
`endif
    input  raw_fault,
    output true_fault,
    output fault_cause,
    output suspect,
    output glitch_cnt
  );

endinterface

// File: rtl/fault_qualifier_sync_ff.sv
// Generic multi-flop synchroniser for asynchronous sensor inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/fault_qualifier.sv
// Qualifies a raw fault into a sticky true_fault: sustained assertion or a glitch burst.
// Optional macro FAULT_CLEAR_EN adds a clear pulse that can leave CONFIRMED.
module fault_qualifier
  import fault_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int CONFIRM_CYCLES = 16,
  parameter int GLITCH_LIMIT   = 4,
  parameter int WINDOW_CYCLES  = 1024
) (
  input logic               clk,
  input logic               reset,
  fault_qualifier_if.slave  bus
);

  localparam int PW = $clog2(CONFIRM_CYCLES + 1);
  localparam int GW = $clog2(GLITCH_LIMIT + 1);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [PW-1:0] CONFIRM_V = PW'(CONFIRM_CYCLES);
  localparam logic [GW-1:0] LIMIT_V   = GW'(GLITCH_LIMIT);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES - 1);

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_persist_cnt, w_persist_next, w_persist_inc;
  logic [GW-1:0] r_glitch_cnt, w_glitch_next, w_glitch_base, w_glitch_inc;
  logic [WW-1:0] r_win_cnt, w_win_next;
  logic [1:0]    r_cause, w_cause_next;
  logic          r_true_fault, r_suspect;
  logic          w_s, w_win_wrap, w_clear;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.raw_fault),
    .q     (w_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_persist_cnt <= '0;
      r_glitch_cnt  <= '0;
      r_win_cnt     <= '0;
      r_cause       <= CAUSE_NONE;
      r_true_fault  <= 1'b0;
      r_suspect     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_persist_cnt <= w_persist_next;
      r_glitch_cnt  <= w_glitch_next;
      r_win_cnt     <= w_win_next;
      r_cause       <= w_cause_next;
      r_true_fault  <= (w_state_next == CONFIRMED);
      r_suspect     <= (w_state_next == SUSPECT);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_persist_next = r_persist_cnt;
    w_glitch_next  = r_glitch_cnt;
    w_win_next     = r_win_cnt;
    w_cause_next   = r_cause;
    w_clear        = 1'b0;
`ifdef FAULT_CLEAR_EN
    w_clear        = bus.clear;
`endif
    w_win_wrap     = (r_win_cnt == WIN_LAST);
    // A glitch ending on a wrap/clear edge counts into the fresh window.
    w_glitch_base  = (w_win_wrap || w_clear) ? '0 : r_glitch_cnt;
    w_glitch_inc   = (w_glitch_base == LIMIT_V) ? LIMIT_V : w_glitch_base + 1'b1;
    w_persist_inc  = r_persist_cnt + 1'b1;

    if (r_state != CONFIRMED) begin
      w_win_next    = (w_win_wrap || w_clear) ? '0 : r_win_cnt + 1'b1;
      w_glitch_next = w_glitch_base;
    end

    case (r_state)
      IDLE: begin
        if (w_s) begin
          if (CONFIRM_CYCLES == 1) begin
            w_state_next = CONFIRMED;
            w_cause_next = CAUSE_PERSIST;
          end else begin
            w_state_next   = SUSPECT;
            w_persist_next = PW'(1);
          end
        end
      end
      SUSPECT: begin
        if (w_s) begin
          w_persist_next = w_persist_inc;
          if (w_persist_inc == CONFIRM_V) begin
            w_state_next = CONFIRMED;
            w_cause_next = CAUSE_PERSIST;
          end
        end else begin
          w_persist_next = '0;
          w_glitch_next  = w_glitch_inc;
          if (w_glitch_inc == LIMIT_V) begin
            w_state_next = CONFIRMED;
            w_cause_next = CAUSE_GLITCH;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      CONFIRMED: begin
`ifdef FAULT_CLEAR_EN
        if (bus.clear && !w_s) begin
          w_state_next   = IDLE;
          w_persist_next = '0;
          w_glitch_next  = '0;
          w_win_next     = '0;
          w_cause_next   = CAUSE_NONE;
        end
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.true_fault  = r_true_fault;
  assign bus.fault_cause = r_cause;
  assign bus.suspect     = r_suspect;
  assign bus.glitch_cnt  = r_glitch_cnt;

endmodule

// File: doc/fault_qualifier.md
Name: fault_qualifier

Overview:
- Producer of the `true_fault` level consumed by the health-indicator latch FSM (`light`/`relay_driver`).
- Synchronises a raw asynchronous fault input from the sensor/comparator path and rejects short glitches.
- Declares a true fault on either of two conditions: sustained assertion, or a burst of glitches within a time window.
- Once declared, `true_fault` is held high until reset, which matches the sticky behaviour of the consumer.

Parameters:
- SYNC_STAGES, 2, number of flops in the `raw_fault` synchroniser (≥2).
- CONFIRM_CYCLES, 16, consecutive synchronised-high samples required to confirm a persistent fault (≥1).
- GLITCH_LIMIT, 4, glitches within one window that confirm a fault (≥1).
- WINDOW_CYCLES, 1024, length of the glitch-counting window in clk cycles (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- raw_fault  in  1  unsynchronised fault indication, active-high
- true_fault  out  1  qualified fault level, sticky
- fault_cause  out  2  00 none, 01 persistent, 10 glitch burst
- suspect  out  1  high while in SUSPECT state
- glitch_cnt  out  $clog2(GLITCH_LIMIT+1)  glitches counted in the current window

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-low.
- Reset values: state=IDLE, synchroniser flops=0, persist_cnt=0, glitch_cnt=0, win_cnt=0, true_fault=0, fault_cause=00, suspect=0.
- Synchroniser: `s` = `raw_fault` after SYNC_STAGES flops. All FSM decisions use `s` only.
- States: IDLE, SUSPECT, CONFIRMED. All outputs are registered and update on the same edge as the state change.
- IDLE:
  - s=1 and CONFIRM_CYCLES=1 → CONFIRMED, cause=01.
  - s=1 otherwise → SUSPECT, persist_cnt=1.
  - s=0 → stay.
- SUSPECT:
  - s=1 → persist_cnt+1. When the new value equals CONFIRM_CYCLES → CONFIRMED, cause=01.
  - s=0 → IDLE, persist_cnt=0, glitch registered: glitch_cnt+1, saturating at GLITCH_LIMIT.
  - If the incremented glitch_cnt equals GLITCH_LIMIT → CONFIRMED, cause=10, instead of IDLE.
- CONFIRMED:
  - `true_fault`=1, cause frozen, counters frozen.
  - Stays until reset, ignoring `s`.
- Latency: first clk edge sampling raw_fault=1 is edge 1. With raw_fault held high, true_fault rises at edge SYNC_STAGES+CONFIRM_CYCLES (18 with defaults).
- Glitch definition: an `s` high run of 1..CONFIRM_CYCLES-1 samples that ends with s=0.
- Window counter:
  - win_cnt is free-running 0..WINDOW_CYCLES-1 and wraps to 0.
  - On the wrap edge glitch_cnt clears to 0.
  - If a glitch registers on the wrap edge, glitch_cnt=1 and no confirm unless GLITCH_LIMIT=1.
  - win_cnt stops in CONFIRMED.
- A glitch spanning a window boundary counts in the window where it ends.
- Reset mid-SUSPECT or mid-CONFIRMED: everything returns to reset values immediately. The synchroniser is refilled from 0, so a held raw_fault re-confirms after the full latency.

Optional Feature:
- Macro: FAULT_CLEAR_EN.
- When defined:
  - Adds input port `clear` (1 bit, synchronous, active-high pulse).
  - In CONFIRMED with clear=1 and s=0 → IDLE on the next edge; true_fault=0, cause=00, all counters=0.
  - clear with s=1 is ignored.
  - clear in IDLE/SUSPECT clears glitch_cnt and win_cnt only.
- When undefined: no `clear` port, and CONFIRMED exits only via reset.

Decomposition:
- Package `fault_pkg`:
  - state enum {IDLE, SUSPECT, CONFIRMED}.
  - fault_cause localparams CAUSE_NONE=2'b00, CAUSE_PERSIST=2'b01, CAUSE_GLITCH=2'b10.
- Sub-module `sync_ff`: parameterised SYNC_STAGES-deep synchroniser with async active-low reset, reusable by other sensor inputs.
- FSM, persistence counter and window counter stay in fault_qualifier.

Test Plan:
- Persistent fault: reset release, then raw_fault=1 held from edge 1 → true_fault=1 exactly at edge 18, cause=01, suspect high edges 3–17.
- Short pulses: 4 raw_fault pulses of 5 cycles, 20 cycles apart, within one window → glitch_cnt 1,2,3 then true_fault=1, cause=10 on the 4th pulse falling edge +2 sync cycles.
- Window clear: 3 glitches, wait past the win_cnt wrap, 1 glitch → glitch_cnt=1, true_fault stays 0.
- Boundary: 15-cycle pulse → glitch, no fault; 16-cycle pulse → fault with cause=01.
- Reset mid-SUSPECT at persist_cnt=10, raw_fault held high → outputs cleared immediately, true_fault rises 18 edges after release.
- FAULT_CLEAR_EN: confirmed fault, clear with raw_fault=1 → ignored; raw_fault=0 for 3 cycles then clear → true_fault=0, cause=00 next edge.
